// File: rtl/memory_cycle_pkg.sv
// rtl/memory_cycle_pkg.sv - shared types and widths for the MEM pipeline stage
package memory_cycle_pkg;

    localparam int DATA_WIDTH     = 18;
    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/memory_cycle_if.sv
// rtl/memory_cycle_if.sv - request/acknowledge data-memory bus
interface memory_cycle_if #(
    parameter int WIDTH = 18
) ();

    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/memwb_reg.sv
// rtl/memwb_reg.sv - MEM/WB pipeline register with bubble insertion
module memwb_reg #(
    parameter int WIDTH  = 18,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              bubble,
    input  logic              reg_write_d,
    input  logic              result_src_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic [WIDTH-1:0]  pc_plus4_d,
    input  logic [WIDTH-1:0]  alu_result_d,
    input  logic [WIDTH-1:0]  read_data_d,
    input  logic [1:0]        rgb_d,
    output logic              reg_write_q,
    output logic              result_src_q,
    output logic [REG_AW-1:0] rd_q,
    output logic [WIDTH-1:0]  pc_plus4_q,
    output logic [WIDTH-1:0]  alu_result_q,
    output logic [WIDTH-1:0]  read_data_q,
    output logic [1:0]        rgb_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            rd_q         <= '0;
            pc_plus4_q   <= '0;
            alu_result_q <= '0;
            read_data_q  <= '0;
            rgb_q        <= '0;
        end else if (load) begin
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            rd_q         <= rd_d;
            pc_plus4_q   <= pc_plus4_d;
            alu_result_q <= alu_result_d;
            read_data_q  <= read_data_d;
            rgb_q        <= rgb_d;
        end else if (bubble) begin
            // Only the write enable is killed; data fields hold for forwarding stability.
            reg_write_q <= 1'b0;
        end
    end

endmodule

// File: rtl/memory_cycle.sv
// rtl/memory_cycle.sv - MEM stage: bus access FSM with timeout, stall and MEM/WB register
module memory_cycle
    import memory_cycle_pkg::*;
#(
    parameter int WIDTH          = DATA_WIDTH,
    parameter int REG_AW         = REG_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteM,
    input  logic              MemWriteM,
    input  logic              ResultSrcM,
    input  logic [REG_AW-1:0] RD_M,
    input  logic [WIDTH-1:0]  PCPlus4M,
    input  logic [WIDTH-1:0]  WriteDataM,
    input  logic [WIDTH-1:0]  ALU_ResultM,
    input  logic [1:0]        RGB_M,
    memory_cycle_if.master    bus,
    output logic              StallM,
    output logic              BusErr,
    output logic              RegWriteW,
    output logic              ResultSrcW,
    output logic [REG_AW-1:0] RD_W,
    output logic [WIDTH-1:0]  PCPlus4W,
    output logic [WIDTH-1:0]  ALU_ResultW,
    output logic [WIDTH-1:0]  ReadDataW,
    output logic [1:0]        RGB_W,
    output logic [WIDTH-1:0]  ResultW
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rdata_q;
    logic             access;
    logic [WIDTH-1:0] wb_read_data;

    assign access = MemWriteM | ResultSrcM;

    // Gated by rst so the stall drops together with the asynchronous state reset.
    always_comb begin
        StallM = 1'b0;
        case (state)
            IDLE:    StallM = access & ~rst;
            ACCESS:  StallM = ~rst;
            default: StallM = 1'b0;
        endcase
    end

    assign wb_read_data = (state == COMPLETE) ? rdata_q : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            BusErr        <= 1'b0;
            rdata_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        bus.mem_addr  <= ALU_ResultM;
                        bus.mem_wdata <= WriteDataM;
                        bus.mem_we    <= MemWriteM;
                        bus.mem_req   <= 1'b1;
                        cnt           <= '0;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (bus.mem_ack) begin
                        rdata_q     <= bus.mem_we ? '0 : bus.mem_rdata;
                        bus.mem_req <= 1'b0;
                        state       <= COMPLETE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        BusErr      <= 1'b1;
                        rdata_q     <= '0;
                        bus.mem_req <= 1'b0;
                        state       <= COMPLETE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                COMPLETE: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    memwb_reg #(
        .WIDTH  (WIDTH),
        .REG_AW (REG_AW)
    ) u_memwb (
        .clk          (clk),
        .rst          (rst),
        .load         (~StallM),
        .bubble       (StallM),
        .reg_write_d  (RegWriteM),
        .result_src_d (ResultSrcM),
        .rd_d         (RD_M),
        .pc_plus4_d   (PCPlus4M),
        .alu_result_d (ALU_ResultM),
        .read_data_d  (wb_read_data),
        .rgb_d        (RGB_M),
        .reg_write_q  (RegWriteW),
        .result_src_q (ResultSrcW),
        .rd_q         (RD_W),
        .pc_plus4_q   (PCPlus4W),
        .alu_result_q (ALU_ResultW),
        .read_data_q  (ReadDataW),
        .rgb_q        (RGB_W)
    );

    assign ResultW = ResultSrcW ? ReadDataW : ALU_ResultW;

endmodule

// File: doc/memory_cycle.md
Name: memory_cycle

Overview:
Pipeline MEM stage, directly downstream of the execute stage. It consumes the EX/MEM register outputs, performs loads and stores over a request/acknowledge data-memory bus, and stalls the pipeline while an access is outstanding. It drives the MEM/WB pipeline register and produces the selected writeback result, which is also used for forwarding.

Parameters:
WIDTH, 18, data and address width
REG_AW, 5, register-index width
TIMEOUT_CYCLES, 16, cycles in ACCESS without mem_ack before abort; must be >=1
CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived)

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  reset, asynchronous, active-high
RegWriteM  in  1  register-write enable from EX/MEM
MemWriteM  in  1  store request
ResultSrcM  in  1  1 = load (result from memory), 0 = ALU result
RD_M  in  REG_AW  destination register
PCPlus4M  in  WIDTH  PC+4
WriteDataM  in  WIDTH  store data
ALU_ResultM  in  WIDTH  ALU result, used as address for loads and stores
RGB_M  in  2  colour-channel tag, passed through
mem_req  out  1  bus request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  WIDTH  bus address
mem_wdata  out  WIDTH  bus write data
mem_rdata  in  WIDTH  bus read data, valid when mem_ack=1
mem_ack  in  1  one-cycle completion pulse
StallM  out  1  freezes IF/ID/EX/EX-MEM registers (to hazard unit)
BusErr  out  1  sticky timeout flag
RegWriteW, ResultSrcW  out  1 each  MEM/WB control
RD_W  out  REG_AW  MEM/WB destination
PCPlus4W, ALU_ResultW, ReadDataW  out  WIDTH each  MEM/WB data
RGB_W  out  2  MEM/WB tag
ResultW  out  WIDTH  ResultSrcW ? ReadDataW : ALU_ResultW (combinational)

Behaviour:
- Reset: state IDLE, counter 0, all mem_* outputs 0, StallM 0, BusErr 0, all W outputs 0, captured read data 0.
- access = MemWriteM | ResultSrcM.
- FSM states: IDLE, ACCESS, COMPLETE.
- IDLE, access=0: StallM=0; MEM/WB register captures the M inputs, with ReadDataW=0. Stay in IDLE.
- IDLE, access=1: StallM=1. On the clock edge, latch mem_addr=ALU_ResultM, mem_wdata=WriteDataM, mem_we=MemWriteM; clear counter; go to ACCESS.
- ACCESS: mem_req=1 (registered, held stable), StallM=1, counter increments each cycle.
  - mem_ack=1: capture mem_rdata (0 if mem_we) into the read-data register, go to COMPLETE.
  - Otherwise, if counter reaches TIMEOUT_CYCLES-1: set BusErr, read data=0, go to COMPLETE.
  - ack and timeout in the same cycle: ack wins; BusErr is not set.
- COMPLETE: mem_req=0, StallM=0. MEM/WB captures the M inputs plus the captured read data. Go to IDLE; the upstream registers advance on the same edge.
- Minimum load/store cost: 2 stall cycles (IDLE, ACCESS with immediate ack), then COMPLETE.
- While StallM=1, MEM/WB loads a bubble: RegWriteW=0, other W fields hold. This prevents duplicate writes and stale forwarding.
- mem_ack outside ACCESS is ignored.
- mem_rdata is sampled only in the ack cycle.
- M inputs are stable while StallM=1; this is guaranteed by the hazard unit.
- Reset mid-ACCESS: mem_req drops asynchronously and the FSM returns to IDLE. The aborted access is not retried.
- BusErr clears only on rst.
- All arithmetic is unsigned; the counter saturates and never wraps.

Decomposition:
- Shared package gets the mem_state_t enum (IDLE, ACCESS, COMPLETE) and the data-width and register-address-width constants.
- The MEM/WB register is a natural sub-module, memwb_reg: load enable = ~StallM, bubble input forces RegWriteW=0.
- The FSM and timeout counter stay in memory_cycle.

Test Plan:
- Non-memory op: RegWriteM=1, RD_M=7, ALU_ResultM=0x00123, ResultSrcM=0 → no stall; next cycle RD_W=7, RegWriteW=1, ResultW=0x00123.
- Load, ack on first ACCESS cycle: ALU_ResultM=0x00040, ResultSrcM=1, mem_rdata=0x2ABCD → StallM high 2 cycles; mem_req=1, mem_we=0, mem_addr=0x00040; after COMPLETE, ReadDataW=ResultW=0x2ABCD.
- Store with ack delayed 5 cycles: MemWriteM=1, WriteDataM=0x15555, address 0x00010 → mem_we=1, mem_wdata=0x15555 held 5 cycles; RegWriteW=0 throughout the stall; BusErr=0.
- No ack, TIMEOUT_CYCLES=16 → mem_req high exactly 16 cycles; BusErr=1, ReadDataW=0; pipeline resumes; BusErr stays 1 until rst.
- Ack in the final timeout cycle → data captured, BusErr=0. Spurious mem_ack in IDLE → no state change.
- Assert rst on the 3rd ACCESS cycle → mem_req, StallM, and all W outputs are 0 immediately. After release, the FSM is in IDLE and the next instruction proceeds normally.
